ifid_hazard_ctrl: RTL and testbench
===================================

Name: ifid_hazard_ctrl

Overview:
- Hazard/sequencing controller for the IF/ID pipeline register and the PC.
- Detects load-use and branch-operand hazards from the ID and EX stage fields, and generates the PC write, IF/ID write, IF flush and ID/EX bubble controls.
- Tracks multi-cycle stalls with an internal state machine.
- Gates fetch on instruction-memory readiness.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- idRs  in  REG_W  rs specifier of the instruction in ID.
- idRt  in  REG_W  rt specifier of the instruction in ID.
- idUsesRs  in  1  the ID instruction reads rs.
- idUsesRt  in  1  the ID instruction reads rt.
- idIsBranch  in  1  the ID instruction is a conditional branch; its operands are compared in ID.
- idRedirect  in  1  branch taken or jump resolved in ID; valid only when operands are ready.
- exMemRead  in  1  the EX instruction is a load.
- exRegWrite  in  1  the EX instruction writes a register.
- exDst  in  REG_W  destination register of the EX instruction.
- imemReady  in  1  instruction memory has the fetch data this cycle.
- pcWrite  out  1  PC load enable.
- ifidWrite  out  1  IF/ID register write enable.
- ifFlush  out  1  IF/ID instruction clear (inserts a NOP).
- idexBubble  out  1  zeroes the ID/EX control fields.
- stallCycles  out  CNT_W  saturating count of cycles with idexBubble=1.
- flushCount  out  CNT_W  saturating count of cycles with ifFlush=1.

Behaviour:
- States: RUN, STALL. State register cnt is 2 bits.
- Reset (rst=0, asynchronous): state=RUN, cnt=0, stallCycles=0, flushCount=0.
- During reset, outputs are pcWrite=1, ifidWrite=1, ifFlush=0, idexBubble=0.
- Control outputs are combinational from state, cnt and the inputs. Counters are registered.
- Match definitions:
  - matchRs = idUsesRs & idRs==exDst & exDst!=0.
  - matchRt = idUsesRt & idRt==exDst & exDst!=0.
  - Register 0 never causes a hazard.
- Hazard classes, evaluated in RUN only; value is the stall length:
  - loadUse: exMemRead & (matchRs|matchRt), 1 cycle.
  - brAlu: idIsBranch & exRegWrite & !exMemRead & (matchRs|matchRt), 1 cycle.
  - brLoad: idIsBranch & exMemRead & (matchRs|matchRt), 2 cycles. Takes precedence over loadUse.
- Stall output set: pcWrite=0, ifidWrite=0, ifFlush=0, idexBubble=1.
- Priority in RUN, highest first:
  - Hazard:
    - Drive the stall output set this cycle.
    - Stall length 1: stay in RUN. Next cycle re-evaluates with the bubble in EX.
    - Stall length 2: go to STALL with cnt=1.
  - idRedirect=1 (only honoured with no hazard):
    - pcWrite=1, ifidWrite=1, ifFlush=1, idexBubble=0.
    - Applies regardless of imemReady; the redirect is never lost.
  - imemReady=0:
    - pcWrite=0, ifidWrite=0, ifFlush=1, idexBubble=0.
    - The ID instruction advances and IF/ID receives a NOP.
  - Otherwise: pcWrite=1, ifidWrite=1, ifFlush=0, idexBubble=0.
- STALL:
  - Drive the stall output set; ignore all hazard, idRedirect and imemReady inputs.
  - Decrement cnt. When cnt==1 at the edge, return to RUN with cnt=0.
  - The ID instruction re-evaluates in RUN the cycle after exit. Its redirect is then honoured.
- Counters:
  - stallCycles increments on every rising edge where idexBubble=1; it holds at all-ones.
  - flushCount does the same for ifFlush=1.
- Reset asserted mid-STALL: immediately RUN, cnt=0; the stall is abandoned.
- Hazard signals are never registered. Only the remaining-stall count carries across cycles.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with garbage inputs -> pcWrite=1, ifidWrite=1, ifFlush=0, idexBubble=0, counters=0; release -> normal flow.
2. Load-use: exMemRead=1, exDst=5, idRs=5, idUsesRs=1 for one cycle, then EX fields cleared -> exactly 1 cycle with pcWrite=0/ifidWrite=0/idexBubble=1, stallCycles=1. Repeat with exDst=0 -> no stall.
3. Branch after load: idIsBranch=1, exMemRead=1, exDst=7, idRt=7, idUsesRt=1, idRedirect=1 -> 2 stall cycles with ifFlush=0; 3rd cycle ifFlush=1, pcWrite=1, flushCount=1. Branch after ALU op (exRegWrite=1, exMemRead=0) -> 1 stall cycle, then the flush.
4. Fetch wait: imemReady=0 for 4 cycles, no hazard -> pcWrite=0, ifidWrite=0, ifFlush=1 each cycle, flushCount=4. Add idRedirect=1 in cycle 2 -> pcWrite=1 that cycle.
5. Reset mid-STALL: trigger brLoad, assert rst after the first stall cycle -> state RUN immediately, outputs at reset values, no further stall after release.
6. Saturation: with CNT_W=4, force 20 consecutive stall cycles -> stallCycles stops at 15.

Source files
------------

// File: rtl/ifid_hazard_ctrl.sv
// rtl/ifid_hazard_ctrl.sv - IF/ID and PC hazard/sequencing control with stall and flush counters
module ifid_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic             idIsBranch,
  input  logic             idRedirect,
  input  logic             exMemRead,
  input  logic             exRegWrite,
  input  logic [REG_W-1:0] exDst,
  input  logic             imemReady,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifFlush,
  output logic             idexBubble,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state;
  logic [1:0] cnt;

  logic matchRs, matchRt, anyMatch;
  logic loadUse, brAlu, brLoad;

  // Register 0 is hardwired, so it can never be the source of a hazard
  assign matchRs  = idUsesRs && (idRs == exDst) && (exDst != '0);
  assign matchRt  = idUsesRt && (idRt == exDst) && (exDst != '0);
  assign anyMatch = matchRs || matchRt;
  assign loadUse  = exMemRead && anyMatch;
  assign brAlu    = idIsBranch && exRegWrite && !exMemRead && anyMatch;
  assign brLoad   = idIsBranch && exMemRead && anyMatch;

  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    ifFlush    = 1'b0;
    idexBubble = 1'b0;
    if (rst) begin
      if (state == STALL || loadUse || brAlu) begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexBubble = 1'b1;
      end else if (idRedirect) begin
        ifFlush = 1'b1;
      end else if (!imemReady) begin
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
        ifFlush   = 1'b1;
      end
    end
  end

  // Only brLoad needs a second stall cycle; single-cycle hazards re-evaluate in RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      cnt         <= 2'd0;
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (brLoad) begin
            state <= STALL;
            cnt   <= 2'd1;
          end
        end
        STALL: begin
          if (cnt <= 2'd1) begin
            state <= RUN;
            cnt   <= 2'd0;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 2'd0;
        end
      endcase
      if (idexBubble && (stallCycles != '1))
        stallCycles <= stallCycles + CNT_W'(1);
      if (ifFlush && (flushCount != '1))
        flushCount <= flushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// tb/tb_ifid_hazard_ctrl.sv - self-checking bench for ifid_hazard_ctrl
module tb_ifid_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;
  localparam int SAT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] idRs, idRt, exDst;
  logic             idUsesRs, idUsesRt, idIsBranch, idRedirect;
  logic             exMemRead, exRegWrite, imemReady;

  logic             pcWrite, ifidWrite, ifFlush, idexBubble;
  logic [CNT_W-1:0] stallCycles, flushCount;
  logic             pcWriteS, ifidWriteS, ifFlushS, idexBubbleS;
  logic [SAT_W-1:0] stallCyclesS, flushCountS;

  ifid_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .idIsBranch(idIsBranch), .idRedirect(idRedirect), .exMemRead(exMemRead),
    .exRegWrite(exRegWrite), .exDst(exDst), .imemReady(imemReady),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifFlush(ifFlush), .idexBubble(idexBubble),
    .stallCycles(stallCycles), .flushCount(flushCount)
  );

  ifid_hazard_ctrl #(.REG_W(REG_W), .CNT_W(SAT_W)) dutSat (
    .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .idIsBranch(idIsBranch), .idRedirect(idRedirect), .exMemRead(exMemRead),
    .exRegWrite(exRegWrite), .exDst(exDst), .imemReady(imemReady),
    .pcWrite(pcWriteS), .ifidWrite(ifidWriteS), .ifFlush(ifFlushS), .idexBubble(idexBubbleS),
    .stallCycles(stallCyclesS), .flushCount(flushCountS)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic       usesRs, usesRt, isBr, redir, memRd, regWr;
    logic [4:0] dst;
    logic       ready;
    logic [3:0] exp;  // {pcWrite, ifidWrite, ifFlush, idexBubble}
  } vec_t;

  vec_t vecs[12];

  int nCmp = 0;
  int nFail = 0;
  int remStall, stallCnt, flushCnt, stallSat, flushSat;
  logic [3:0] lastCtl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stall length demanded by the current inputs, straight from the hazard rules
  function automatic int hazLen();
    bit m;
    m = (idUsesRs && idRs == exDst && exDst != 0) || (idUsesRt && idRt == exDst && exDst != 0);
    if (idIsBranch && exMemRead && m) return 2;
    if (exMemRead && m) return 1;
    if (idIsBranch && exRegWrite && !exMemRead && m) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] modelCtl();
    if (!rst) return 4'b1100;
    if (remStall > 0 || hazLen() != 0) return 4'b0001;
    if (idRedirect) return 4'b1110;
    if (!imemReady) return 4'b0010;
    return 4'b1100;
  endfunction

  function automatic int satInc(input int v, input int maxV);
    return (v >= maxV) ? maxV : v + 1;
  endfunction

  // Inputs are set at posedge+1; outputs checked on the following negedge
  task automatic tick(input string nm);
    logic [3:0] e;
    int h;
    #4;
    if (!rst) begin
      remStall = 0; stallCnt = 0; flushCnt = 0; stallSat = 0; flushSat = 0;
    end
    e = modelCtl();
    h = hazLen();
    lastCtl = {pcWrite, ifidWrite, ifFlush, idexBubble};
    chk({nm, ".ctl"}, 32'(lastCtl), 32'(e));
    chk({nm, ".stallCycles"}, 32'(stallCycles), stallCnt);
    chk({nm, ".flushCount"}, 32'(flushCount), flushCnt);
    chk({nm, ".satStall"}, 32'(stallCyclesS), stallSat);
    chk({nm, ".satFlush"}, 32'(flushCountS), flushSat);
    @(posedge clk);
    if (rst) begin
      if (e[0]) begin
        stallCnt = satInc(stallCnt, 65535);
        stallSat = satInc(stallSat, 15);
      end
      if (e[1]) begin
        flushCnt = satInc(flushCnt, 65535);
        flushSat = satInc(flushSat, 15);
      end
      remStall = (remStall > 0) ? remStall - 1 : ((h == 2) ? 1 : 0);
    end
    #1;
  endtask

  task automatic setIdle();
    idRs = 5'd1; idRt = 5'd2; idUsesRs = 0; idUsesRt = 0; idIsBranch = 0; idRedirect = 0;
    exMemRead = 0; exRegWrite = 0; exDst = 5'd0; imemReady = 1;
  endtask

  task automatic randInputs(input int regMax);
    idRs = 5'($urandom_range(0, regMax)); idRt = 5'($urandom_range(0, regMax));
    exDst = 5'($urandom_range(0, regMax));
    idUsesRs = 1'($urandom); idUsesRt = 1'($urandom); idIsBranch = 1'($urandom);
    idRedirect = 1'($urandom); exMemRead = 1'($urandom); exRegWrite = 1'($urandom);
    imemReady = ($urandom_range(0, 3) != 0);
  endtask

  task automatic doReset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      randInputs(3);
      tick("reset");
      chk("reset.ctl", 32'(lastCtl), 32'(4'b1100));
    end
    rst = 1'b1;
    setIdle();
  endtask

  task automatic applyVec(input vec_t v);
    idRs = v.rs; idRt = v.rt; idUsesRs = v.usesRs; idUsesRt = v.usesRt; idIsBranch = v.isBr;
    idRedirect = v.redir; exMemRead = v.memRd; exRegWrite = v.regWr; exDst = v.dst;
    imemReady = v.ready;
  endtask

  initial begin
    //           rs  rt us ut br rd mr rw dst rdy exp
    vecs[0]  = '{5'd1, 5'd2, 1, 1, 0, 0, 0, 0, 5'd3, 1, 4'b1100};
    vecs[1]  = '{5'd5, 5'd2, 1, 0, 0, 0, 1, 1, 5'd5, 1, 4'b0001};
    vecs[2]  = '{5'd1, 5'd9, 0, 1, 0, 0, 1, 1, 5'd9, 1, 4'b0001};
    vecs[3]  = '{5'd0, 5'd0, 1, 1, 0, 0, 1, 1, 5'd0, 1, 4'b1100};
    vecs[4]  = '{5'd5, 5'd2, 0, 0, 0, 0, 1, 1, 5'd5, 1, 4'b1100};
    vecs[5]  = '{5'd4, 5'd2, 1, 0, 1, 1, 0, 1, 5'd4, 1, 4'b0001};
    vecs[6]  = '{5'd4, 5'd2, 1, 0, 0, 0, 0, 1, 5'd4, 1, 4'b1100};
    vecs[7]  = '{5'd4, 5'd2, 1, 0, 1, 1, 0, 0, 5'd4, 1, 4'b1110};
    vecs[8]  = '{5'd1, 5'd2, 0, 0, 0, 1, 0, 0, 5'd3, 0, 4'b1110};
    vecs[9]  = '{5'd1, 5'd2, 0, 0, 0, 0, 0, 0, 5'd3, 0, 4'b0010};
    vecs[10] = '{5'd6, 5'd2, 1, 0, 0, 1, 1, 0, 5'd6, 0, 4'b0001};
    vecs[11] = '{5'd4, 5'd8, 1, 1, 1, 1, 0, 1, 5'd3, 1, 4'b1110};

    remStall = 0; stallCnt = 0; flushCnt = 0; stallSat = 0; flushSat = 0;
    lastCtl = '0;
    setIdle();
    rst = 1'b0;
    @(posedge clk); #1;
    doReset(3);
    tick("release");
    chk("release.ctl", 32'(lastCtl), 32'(4'b1100));

    for (int i = 0; i < 12; i++) begin
      applyVec(vecs[i]);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.exp", i), 32'(lastCtl), 32'(vecs[i].exp));
    end

    // Load-use: one bubble, then none once EX holds the bubble; exDst=0 never stalls
    doReset(1);
    idRs = 5'd5; idUsesRs = 1; exMemRead = 1; exDst = 5'd5;
    tick("lu1");
    chk("lu1.exp", 32'(lastCtl), 32'(4'b0001));
    exMemRead = 0; exDst = 5'd0;
    tick("lu2");
    chk("lu2.exp", 32'(lastCtl), 32'(4'b1100));
    chk("lu.stallCycles", 32'(stallCycles), 32'd1);
    exMemRead = 1; exDst = 5'd0; idRs = 5'd0;
    tick("lu0");
    chk("lu0.exp", 32'(lastCtl), 32'(4'b1100));

    // Branch after load: two stall cycles, inputs ignored in the second, then the redirect
    doReset(1);
    idIsBranch = 1; exMemRead = 1; exDst = 5'd7; idRt = 5'd7; idUsesRt = 1; idRedirect = 1;
    tick("bl1");
    chk("bl1.exp", 32'(lastCtl), 32'(4'b0001));
    exMemRead = 0; exDst = 5'd0; imemReady = 0;
    tick("bl2");
    chk("bl2.exp", 32'(lastCtl), 32'(4'b0001));
    imemReady = 1;
    tick("bl3");
    chk("bl3.exp", 32'(lastCtl), 32'(4'b1110));
    setIdle();
    tick("bl4");
    chk("bl.stallCycles", 32'(stallCycles), 32'd2);
    chk("bl.flushCount", 32'(flushCount), 32'd1);

    // Branch after ALU op: single stall then the flush
    doReset(1);
    idIsBranch = 1; exRegWrite = 1; exDst = 5'd6; idRs = 5'd6; idUsesRs = 1; idRedirect = 1;
    tick("ba1");
    chk("ba1.exp", 32'(lastCtl), 32'(4'b0001));
    exRegWrite = 0; exDst = 5'd0;
    tick("ba2");
    chk("ba2.exp", 32'(lastCtl), 32'(4'b1110));
    setIdle();
    tick("ba3");
    chk("ba.stallCycles", 32'(stallCycles), 32'd1);
    chk("ba.flushCount", 32'(flushCount), 32'd1);

    // Fetch wait with a redirect landing in the second cycle
    doReset(1);
    imemReady = 0;
    tick("fw1");
    chk("fw1.exp", 32'(lastCtl), 32'(4'b0010));
    idRedirect = 1;
    tick("fw2");
    chk("fw2.exp", 32'(lastCtl), 32'(4'b1110));
    idRedirect = 0;
    tick("fw3");
    tick("fw4");
    chk("fw4.exp", 32'(lastCtl), 32'(4'b0010));
    setIdle();
    tick("fw5");
    chk("fw.flushCount", 32'(flushCount), 32'd4);

    // Reset during STALL abandons the remaining stall cycle
    doReset(1);
    idIsBranch = 1; exMemRead = 1; exDst = 5'd7; idRt = 5'd7; idUsesRt = 1;
    tick("rs1");
    chk("rs1.exp", 32'(lastCtl), 32'(4'b0001));
    rst = 1'b0;
    tick("rs2");
    chk("rs2.exp", 32'(lastCtl), 32'(4'b1100));
    chk("rs2.stallCycles", 32'(stallCycles), 32'd0);
    rst = 1'b1;
    setIdle();
    tick("rs3");
    chk("rs3.exp", 32'(lastCtl), 32'(4'b1100));
    tick("rs4");
    chk("rs4.stallCycles", 32'(stallCycles), 32'd0);

    // Saturation of the narrow counter
    doReset(1);
    idRs = 5'd5; idUsesRs = 1; exMemRead = 1; exDst = 5'd5;
    for (int i = 0; i < 20; i++) tick("sat");
    setIdle();
    tick("satEnd");
    chk("sat.narrow", 32'(stallCyclesS), 32'd15);
    chk("sat.wide", 32'(stallCycles), 32'd20);

    // Randomized run against the model, with occasional resets
    doReset(1);
    for (int i = 0; i < 3000; i++) begin
      randInputs(3);
      rst = ($urandom_range(0, 99) != 0);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
